// File: rtl/mantle_lane_pkg.sv
// Shared encodings for the lane permute block: permutation modes and FIFO occupancy states.
package mantle_lane_pkg;

  typedef enum logic [1:0] {
    MODE_PASS   = 2'b00,
    MODE_REV    = 2'b01,
    MODE_ROT    = 2'b10,
    MODE_BITREV = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/mantle_lane_perm.sv
// Combinational lane permutation: pass, lane reverse, lane rotate-left, per-lane bit reverse.
// Zero latency, no state and no flow control.
module mantle_lane_perm
  import mantle_lane_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LANE  = 8
) (
  input  logic [WIDTH-1:0]              in_data,
  input  logic [1:0]                    mode,
  input  logic [$clog2(WIDTH/LANE)-1:0] rot,
  output logic [WIDTH-1:0]              out_data
);

  localparam int NL = WIDTH / LANE;
  localparam int RW = $clog2(NL);

  if (WIDTH % LANE != 0 || NL < 2) begin : g_bad_params
    $error("mantle_lane_perm: WIDTH must be a multiple of LANE with at least two lanes");
  end

  // Rotate amounts at or beyond the lane count wrap; only matters when NL is not a power of two.
  logic [RW-1:0] rot_m;
  assign rot_m = RW'(int'(rot) % NL);

  always_comb begin
    out_data = in_data;
    case (mode_e'(mode))
      MODE_PASS: out_data = in_data;
      MODE_REV:
        for (int i = 0; i < NL; i++)
          out_data[(NL-1-i)*LANE +: LANE] = in_data[i*LANE +: LANE];
      MODE_ROT:
        for (int j = 0; j < NL; j++)
          for (int i = 0; i < NL; i++)
            if ((i + int'(rot_m)) % NL == j)
              out_data[j*LANE +: LANE] = in_data[i*LANE +: LANE];
      MODE_BITREV:
        for (int i = 0; i < NL; i++)
          for (int b = 0; b < LANE; b++)
            out_data[i*LANE + b] = in_data[i*LANE + LANE - 1 - b];
      default: out_data = in_data;
    endcase
  end

endmodule

// File: rtl/mantle_lane_permute.sv
// Lane permute in front of a 2-entry FIFO; an accepted word is visible on out_data the next cycle.
// Backpressure: registered in_ready drops only when the FIFO is about to be full.
module mantle_lane_permute
  import mantle_lane_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LANE  = 8
) (
  input  logic                          CLK,
  input  logic                          ASYNCRESETN,
  input  logic [WIDTH-1:0]              in_data,
  input  logic [1:0]                    in_mode,
  input  logic [$clog2(WIDTH/LANE)-1:0] in_rot,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [1:0]                    count
);

  if (WIDTH % LANE != 0 || WIDTH / LANE < 2) begin : g_bad_params
    $error("mantle_lane_permute: WIDTH must be a multiple of LANE with at least two lanes");
  end

  logic [WIDTH-1:0] perm_data;
  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             push;
  logic             pop;
  occ_e             state_q;
  occ_e             state_d;

  mantle_lane_perm #(
    .WIDTH (WIDTH),
    .LANE  (LANE)
  ) u_perm (
    .in_data  (in_data),
    .mode     (in_mode),
    .rot      (in_rot),
    .out_data (perm_data)
  );

  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_valid = (state_q != OCC_EMPTY);
  assign out_data  = mem[rd_ptr];
  assign count     = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      OCC_EMPTY: if (push) state_d = OCC_ONE;
      OCC_ONE: begin
        if (push && !pop)      state_d = OCC_FULL;
        else if (pop && !push) state_d = OCC_EMPTY;
      end
      OCC_FULL:  if (pop && !push) state_d = OCC_ONE;
      default:   state_d = OCC_EMPTY;
    endcase
  end

  // in_ready looks at the next occupancy so the sink's out_ready never reaches it combinationally.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q  <= OCC_EMPTY;
      in_ready <= 1'b0;
    end else begin
      state_q  <= state_d;
      in_ready <= (state_d != OCC_FULL);
    end
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= perm_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
    end
  end

endmodule

// File: tb/tb_mantle_lane_permute.sv
// Randomized scoreboard bench for mantle_lane_permute with 2, 3 and 4 lanes of 8 bits driven in lockstep.
module tb_mantle_lane_permute;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] in_data;
  logic [1:0]  in_mode;
  logic [1:0]  in_rot;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] od16;
  logic [23:0] od24;
  logic [31:0] od32;
  logic [1:0]  cnt16, cnt24, cnt32;
  logic        ir16, ir24, ir32;
  logic        ov16, ov24, ov32;

  mantle_lane_permute #(.WIDTH(16), .LANE(8)) dut16 (
    .CLK(clk), .ASYNCRESETN(rst_n), .in_data(in_data[15:0]), .in_mode(in_mode),
    .in_rot(in_rot[0:0]), .in_valid(in_valid), .in_ready(ir16), .out_data(od16),
    .out_valid(ov16), .out_ready(out_ready), .count(cnt16));

  mantle_lane_permute #(.WIDTH(24), .LANE(8)) dut24 (
    .CLK(clk), .ASYNCRESETN(rst_n), .in_data(in_data[23:0]), .in_mode(in_mode),
    .in_rot(in_rot), .in_valid(in_valid), .in_ready(ir24), .out_data(od24),
    .out_valid(ov24), .out_ready(out_ready), .count(cnt24));

  mantle_lane_permute #(.WIDTH(32), .LANE(8)) dut32 (
    .CLK(clk), .ASYNCRESETN(rst_n), .in_data(in_data), .in_mode(in_mode),
    .in_rot(in_rot), .in_valid(in_valid), .in_ready(ir32), .out_data(od32),
    .out_valid(ov32), .out_ready(out_ready), .count(cnt32));

  typedef logic [2:0][31:0] exp_t;
  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  function automatic logic [31:0] dut_out(input int k);
    case (k)
      0:       return {16'h0, od16};
      1:       return {8'h0, od24};
      default: return od32;
    endcase
  endfunction

  function automatic logic dut_vld(input int k);
    return (k == 0) ? ov16 : (k == 1) ? ov24 : ov32;
  endfunction

  function automatic logic dut_rdy(input int k);
    return (k == 0) ? ir16 : (k == 1) ? ir24 : ir32;
  endfunction

  function automatic logic [1:0] dut_cnt(input int k);
    return (k == 0) ? cnt16 : (k == 1) ? cnt24 : cnt32;
  endfunction

  // Reference: split into lanes, move whole lanes by index arithmetic, reassemble.
  function automatic logic [31:0] ref_perm(input logic [31:0] d, input int nl,
                                           input logic [1:0] mode, input int rot);
    logic [7:0]  lin  [4];
    logic [7:0]  lout [4];
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      lin[i]  = (i < nl) ? d[i*8 +: 8] : 8'h0;
      lout[i] = 8'h0;
    end
    for (int i = 0; i < nl; i++) begin
      case (mode)
        2'b00:   lout[i]              = lin[i];
        2'b01:   lout[nl-1-i]         = lin[i];
        2'b10:   lout[(i + rot) % nl] = lin[i];
        default: lout[i]              = {<<{lin[i]}};
      endcase
    end
    r = {lout[3], lout[2], lout[1], lout[0]};
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the edge that took the word.
  task automatic send_one(input logic [31:0] d, input logic [1:0] m, input logic [1:0] r,
                          output int waits);
    exp_t e;
    bit   done;
    done     = 1'b0;
    waits    = 0;
    in_data  = d;
    in_mode  = m;
    in_rot   = r;
    in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (ir16) begin
        for (int k = 0; k < 3; k++) e[k] = ref_perm(d, k + 2, m, int'(r));
        sb.push_back(e);
        done = 1'b1;
      end else if (waits >= 50) begin
        tests++;
        fails++;
        $display("FAIL in_ready timeout: waited %0d cycles, expected acceptance", waits);
        in_valid = 1'b0;
        done     = 1'b1;
      end else begin
        waits++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every output transfer and checks stall stability.
  initial begin
    logic [31:0] held [3];
    bit          stalled;
    exp_t        e;
    stalled = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 1'b0;
      end else begin
        if (stalled)
          for (int k = 0; k < 3; k++) check($sformatf("hold_stable[%0d]", k), dut_out(k), held[k]);
        if (ov16 && out_ready) begin
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_output: got 0x%0h, expected no word", od16);
          end else begin
            e = sb.pop_front();
            for (int k = 0; k < 3; k++) begin
              check($sformatf("out_valid[%0d]", k), {31'b0, dut_vld(k)}, 32'h1);
              check($sformatf("out_data[%0d]", k), dut_out(k), e[k]);
            end
          end
        end
        stalled = ov16 && !out_ready;
        for (int k = 0; k < 3; k++) held[k] = dut_out(k);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete, %0d failures so far", fails);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  w, w3;
    bit  bp_done;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = '0;
    in_rot    = '0;
    out_ready = 1'b0;
    bp_done   = 1'b0;

    #12;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset_count[%0d]", k), {30'b0, dut_cnt(k)}, 32'h0);
      check($sformatf("reset_out_valid[%0d]", k), {31'b0, dut_vld(k)}, 32'h0);
      check($sformatf("reset_out_data[%0d]", k), dut_out(k), 32'h0);
      check($sformatf("reset_in_ready[%0d]", k), {31'b0, dut_rdy(k)}, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("in_ready_before_first_edge", {31'b0, ir16}, 32'h0);
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++)
      check($sformatf("in_ready_after_first_edge[%0d]", k), {31'b0, dut_rdy(k)}, 32'h1);

    // Directed vectors.
    out_ready = 1'b1;
    send_one(32'h0000_12AB, 2'b01, 2'd0, w);
    check("rev16_valid", {31'b0, ov16}, 32'h1);
    check("rev16_data", {16'h0, od16}, 32'h0000_AB12);
    @(posedge clk);
    #1;
    check("rev16_count_back_to_0", {30'b0, cnt16}, 32'h0);
    send_one(32'h1122_3344, 2'b10, 2'd1, w);
    check("rot32_by1", od32, 32'h2233_4411);
    @(posedge clk);
    #1;
    send_one(32'h1122_3344, 2'b10, 2'd3, w);
    check("rot32_by3", od32, 32'h4411_2233);
    @(posedge clk);
    #1;
    send_one(32'h0000_0180, 2'b11, 2'd0, w);
    check("bitrev16", {16'h0, od16}, 32'h0000_8001);
    @(posedge clk);
    #1;
    send_one(32'h0000_0180, 2'b00, 2'd0, w);
    check("pass16", {16'h0, od16}, 32'h0000_0180);
    @(posedge clk);
    #1;

    // Fill to two entries under backpressure, hold the third at the source, then drain.
    out_ready = 1'b0;
    send_one(32'h1, 2'b00, 2'd0, w);
    send_one(32'h2, 2'b00, 2'd0, w);
    check("full_count", {30'b0, cnt16}, 32'h2);
    check("full_in_ready", {31'b0, ir16}, 32'h0);
    fork
      send_one(32'h3, 2'b00, 2'd0, w3);
      begin
        @(posedge clk);
        #1;
        check("held_count", {30'b0, cnt16}, 32'h2);
        check("held_in_ready", {31'b0, ir16}, 32'h0);
        out_ready = 1'b1;
        repeat (3) begin
          @(negedge clk);
          check("drain_no_gap", {31'b0, ov16}, 32'h1);
        end
      end
    join
    @(posedge clk);
    #1;
    check("drain_count", {30'b0, cnt16}, 32'h0);
    check("drain_scoreboard_empty", sb.size(), 32'h0);

    // Reset while full: everything buffered is discarded.
    out_ready = 1'b0;
    send_one($urandom(), 2'b01, 2'd0, w);
    send_one($urandom(), 2'b10, 2'd2, w);
    check("pre_reset_count", {30'b0, cnt16}, 32'h2);
    #3;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("midreset_out_valid[%0d]", k), {31'b0, dut_vld(k)}, 32'h0);
      check($sformatf("midreset_count[%0d]", k), {30'b0, dut_cnt(k)}, 32'h0);
      check($sformatf("midreset_out_data[%0d]", k), dut_out(k), 32'h0);
    end
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    check("rerelease_in_ready_low", {31'b0, ir16}, 32'h0);
    @(posedge clk);
    #1;
    check("rerelease_in_ready_high", {31'b0, ir16}, 32'h1);
    repeat (4) begin
      @(negedge clk);
      check("no_stale_output", {31'b0, ov16}, 32'h0);
    end
    @(posedge clk);
    #1;

    // Sustained streaming: one word per cycle, in_ready must never drop.
    for (int n = 0; n < 100; n++) begin
      send_one($urandom(), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), w);
      check("stream_no_stall", w, 32'h0);
    end

    // Random source gaps against random sink backpressure.
    fork
      begin
        for (int n = 0; n < 150; n++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          send_one($urandom(), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), w);
        end
        bp_done = 1'b1;
      end
      while (!bp_done) begin
        @(posedge clk);
        #1;
        out_ready = 1'($urandom_range(0, 1));
      end
    join
    out_ready = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    check("final_scoreboard_empty", sb.size(), 32'h0);
    check("final_count", {30'b0, cnt16}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
